adder_rr_scheduler: RTL
=======================

Name: adder_rr_scheduler

Overview:
- Shares one registered 16-bit adder (1-cycle latency, async active-high reset) between NUM_REQ requesters.
- Each requester holds operands and valid. The scheduler grants one requester at a time in round-robin order and drives the adder operands.
- It captures sum/cout/overflow one cycle later and returns them tagged with the requester id over a valid/ready response port.
- Sits between client engines and the shared adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/sum width; must match the adder's WIDTH.
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operation pending.
- req_ready  output  NUM_REQ  one-hot grant; acceptance = req_valid[i] & req_ready[i].
- req_a  input  NUM_REQ*WIDTH  packed operand A; slice i = [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  packed operand B.
- req_cin  input  NUM_REQ  per-requester carry-in.
- add_a  output  WIDTH  to adder a.
- add_b  output  WIDTH  to adder b.
- add_cin  output  1  to adder cin.
- add_sum  input  WIDTH  from adder sum.
- add_cout  input  1  from adder cout.
- add_overflow  input  1  from adder overflow.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  ID_W  index of the requester served.
- rsp_sum  output  WIDTH  captured sum.
- rsp_cout  output  1  captured carry-out.
- rsp_overflow  output  1  captured signed overflow.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; add_a=0, add_b=0, add_cin=0; rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_overflow=0; busy=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation drops any in-flight or held response; no response is emitted after reset.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - req_ready is combinational one-hot of the first req_valid found searching from last_grant+1 upward, wrapping modulo NUM_REQ. All zero if no req_valid.
  - On a grant: register the granted slice into add_a/add_b/add_cin, latch grant id, set last_grant=id, go to ISSUE.
  - req_ready is 0 in every state except IDLE.
- ISSUE (1 cycle): add_* held stable; the adder registers them at the end of this cycle. Go to CAPTURE.
- CAPTURE (1 cycle): add_sum/add_cout/add_overflow are valid. Latch them into rsp_sum/rsp_cout/rsp_overflow, set rsp_id, set rsp_valid=1 at the next edge, go to RESP.
- RESP: hold rsp_* stable while rsp_valid=1 and rsp_ready=0. On rsp_valid & rsp_ready: clear rsp_valid, go to IDLE.
- add_a/add_b/add_cin keep the last issued values outside ISSUE; they are not cleared.
- Throughput: at most one operation per 4 cycles with rsp_ready held high.
- Latency from accept edge to rsp_valid high: 3 cycles.
- Fairness: a requester with valid held high is granted within NUM_REQ operations.
- Requesters hold valid/operands stable until accepted. Dropping valid before grant is legal and loses nothing.
- The scheduler does no arithmetic; results are passed through exactly as the adder computed them.

Optional Feature:
- ADDER_RR_SCHEDULER_STATS_EN: adds output ports op_count (32-bit) and ovf_count (16-bit).
  - op_count increments on each response handshake.
  - ovf_count increments on each response handshake where rsp_overflow=1.
  - Both counters saturate at all-ones and reset to 0.
- Without the macro: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single op: req 0 with a=0x0001, b=0x0002, cin=1 -> after 3 cycles rsp_valid=1, rsp_id=0, sum=0x0004, cout=0, overflow=0.
- Carry/overflow: req 2 with a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
- Round-robin: all 4 req_valid held high from reset, rsp_ready=1 -> grant order 0,1,2,3,0; each grant 4 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles during RESP -> rsp_* stable, req_ready all 0. rsp_ready=1 -> handshake, next grant the cycle after.
- Reset mid-op: assert rst in CAPTURE -> rsp_valid=0 immediately. After release, requester 0 (if valid) is granted first.
- STATS (macro on): 5 ops, 2 with overflow -> op_count=5, ovf_count=2.

Source files
------------

// File: rtl/adder_rr_scheduler.sv
// ============================================================================
// Module   : adder_rr_scheduler
// Brief    : Round-robin scheduler sharing one registered adder between
//            NUM_REQ requesters; results return over a valid/ready port.
//            Optional stats counters: ADDER_RR_SCHEDULER_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]         req_cin,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  output logic                       add_cin,
  input  logic [WIDTH-1:0]           add_sum,
  input  logic                       add_cout,
  input  logic                       add_overflow,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout,
  output logic                       rsp_overflow,
  output logic                       busy
`ifdef ADDER_RR_SCHEDULER_STATS_EN
  ,
  output logic [31:0]                op_count,
  output logic [15:0]                ovf_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_last_grant;
  logic [ID_W-1:0] r_grant_id;
  logic [ID_W-1:0] w_pick_id;
  logic [ID_W-1:0] w_idx;
  logic            w_pick_found;
  logic            w_accept;

  // First pending requester after the last one served, wrapping around.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    w_idx        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_pick_found && req_valid[w_idx]) begin
        w_pick_found = 1'b1;
        w_pick_id    = w_idx;
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && w_pick_found;
  assign req_ready = w_accept ? (NUM_REQ'(1) << w_pick_id) : '0;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_pick_found) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_RESP;
      S_RESP:    if (rsp_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_grant_id   <= '0;
      add_a        <= '0;
      add_b        <= '0;
      add_cin      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      // Operands stay on the adder inputs until the next grant.
      if (w_accept) begin
        add_a        <= req_a[w_pick_id*WIDTH +: WIDTH];
        add_b        <= req_b[w_pick_id*WIDTH +: WIDTH];
        add_cin      <= req_cin[w_pick_id];
        r_grant_id   <= w_pick_id;
        r_last_grant <= w_pick_id;
      end
      if (r_state == S_CAPTURE) begin
        rsp_sum      <= add_sum;
        rsp_cout     <= add_cout;
        rsp_overflow <= add_overflow;
        rsp_id       <= r_grant_id;
        rsp_valid    <= 1'b1;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        rsp_valid    <= 1'b0;
      end
    end
  end

`ifdef ADDER_RR_SCHEDULER_STATS_EN
  logic w_rsp_hs;
  assign w_rsp_hs = rsp_valid & rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (w_rsp_hs) begin
      if (op_count != '1) op_count <= op_count + 32'd1;
      if (rsp_overflow && (ovf_count != '1)) ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
